// File: rtl/imm_ext_pipe_pkg.sv
// Shared encodings, field positions and stage-1 record for the immediate extender.
package imm_ext_pipe_pkg;

  typedef enum logic [2:0] {
    IMM_DP_ROT = 3'b000,
    IMM_MEM12  = 3'b001,
    IMM_BRANCH = 3'b010,
    IMM_HALF8  = 3'b011,
    IMM_ZEXT8  = 3'b100
  } imm_src_e;

  localparam int INSTR_W       = 24;
  localparam int ROT_FIELD_LSB = 8;
  localparam int ROT_FIELD_W   = 4;
  // Rotate amount is taken modulo 32, so 5 bits always suffice.
  localparam int ROT_W         = 5;

  // Everything stage 2 needs, captured at accept time.
  typedef struct packed {
    logic [2:0]         mode;
    logic [INSTR_W-1:0] instr;
    logic [ROT_W-1:0]   rot;
    logic               u;
    logic               carry_in;
  } s1_t;

  // Scaled rotate amount, wrapped to the 32-bit rotate range.
  function automatic logic [ROT_W-1:0] rot_amt(input logic [ROT_FIELD_W-1:0] field,
                                               input int step);
    return ROT_W'(int'(field) * step);
  endfunction

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Request/response handshake bundle between the core and the immediate extender.
interface imm_ext_if #(parameter int DATA_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [23:0]       instr;
  logic [2:0]        imm_src;
  logic              carry_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ext_imm;
  logic              carry_out;
  logic              illegal;

  // Core side: issues requests, consumes results.
  modport master (
    output in_valid, instr, imm_src, carry_in, out_ready,
    input  in_ready, out_valid, ext_imm, carry_out, illegal
  );

  // Extender side.
  modport slave (
    input  in_valid, instr, imm_src, carry_in, out_ready,
    output in_ready, out_valid, ext_imm, carry_out, illegal
  );
endinterface

// File: rtl/imm_ext_pipe_rotator.sv
// 32-bit rotate-right with ARM shifter carry select (carry passes through on rot=0).
module imm_rotator (
  input  logic [31:0] data,
  input  logic [4:0]  rot,
  input  logic        carry_in,
  output logic [31:0] result,
  output logic        carry_out
);
  // A shift by 32 yields zero, so rot=0 collapses to the plain input.
  assign result    = (data >> rot) | (data << (6'd32 - {1'b0, rot}));
  assign carry_out = (rot == '0) ? carry_in : result[31];
endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage valid/ready immediate extender: stage 1 captures fields,
// stage 2 decodes and registers the operand, plus a saturating illegal counter.
module imm_ext_pipe
  import imm_ext_pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ROT_STEP  = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imm_ext_if.slave             bus,
  input  logic                 clr_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic s1_valid, s2_valid, s1_adv, s2_adv, in_fire;
  s1_t  s1;

  logic [31:0]       rot_res;
  logic              rot_c;
  logic [DATA_W-1:0] nxt_imm, mag;
  logic              nxt_c, nxt_ill;

  logic [DATA_W-1:0] ext_r;
  logic              carry_r, ill_r;

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = s1_valid && s2_adv;
  assign bus.in_ready = !s1_valid || s2_adv;
  assign in_fire      = bus.in_valid && bus.in_ready;

  // Stage 1: capture request fields and the pre-scaled rotate amount.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (in_fire)
        s1 <= '{mode:     bus.imm_src,
                instr:    bus.instr,
                rot:      rot_amt(bus.instr[ROT_FIELD_LSB +: ROT_FIELD_W], ROT_STEP),
                u:        bus.instr[23],
                carry_in: bus.carry_in};
    end
  end

  imm_rotator u_rot (
    .data      ({24'b0, s1.instr[7:0]}),
    .rot       (s1.rot),
    .carry_in  (s1.carry_in),
    .result    (rot_res),
    .carry_out (rot_c)
  );

  // Stage 2 decode: pick the operand for the captured mode.
  always_comb begin
    nxt_imm = '0;
    nxt_c   = 1'b0;
    nxt_ill = 1'b0;
    mag     = '0;
    case (s1.mode)
      IMM_DP_ROT: begin
        nxt_imm = DATA_W'(rot_res);
        nxt_c   = rot_c;
      end
      IMM_MEM12: begin
        mag     = DATA_W'(s1.instr[11:0]);
        nxt_imm = s1.u ? mag : -mag;
      end
      IMM_BRANCH: nxt_imm = {{(DATA_W-26){s1.instr[23]}}, s1.instr, 2'b00};
      IMM_HALF8: begin
        mag     = DATA_W'({s1.instr[11:8], s1.instr[3:0]});
        nxt_imm = s1.u ? mag : -mag;
      end
      IMM_ZEXT8:  nxt_imm = DATA_W'(s1.instr[7:0]);
      default:    nxt_ill = 1'b1;
    endcase
  end

  // Stage 2: register the result; hold it while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      ext_r    <= '0;
      carry_r  <= 1'b0;
      ill_r    <= 1'b0;
    end else begin
      if (s2_adv) s2_valid <= s1_valid;
      if (s1_adv) begin
        ext_r   <= nxt_imm;
        carry_r <= nxt_c;
        ill_r   <= nxt_ill;
      end
    end
  end

  // Illegal counter: clear wins over increment, saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    err_cnt <= '0;
    else if (clr_err)                              err_cnt <= '0;
    else if (s1_adv && nxt_ill && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
  end

  assign bus.out_valid = s2_valid;
  assign bus.ext_imm   = ext_r;
  assign bus.carry_out = carry_r;
  assign bus.illegal   = ill_r;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: vector table plus stream, counter and reset sequences.
module tb_imm_ext_pipe;
  import imm_ext_pipe_pkg::*;

  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] err_cnt;

  imm_ext_if #(.DATA_W(DW)) bus ();

  imm_ext_pipe #(.DATA_W(DW), .ROT_STEP(2), .ERR_CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .clr_err (clr_err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  src;
    logic [23:0] instr;
    logic        cin;
    logic [31:0] imm;
    logic        cout;
    logic        ill;
    string       name;
  } vec_t;

  vec_t vecs[15];

  // One isolated request: accept, confirm 2-cycle latency, compare result.
  task automatic send_one(input vec_t v);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.imm_src   = v.src;
    bus.instr     = v.instr;
    bus.carry_in  = v.cin;
    bus.out_ready = 1'b1;
    #1 check({v.name, " in_ready"}, bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check({v.name, " early out_valid"}, bus.out_valid, 1'b0);
    @(negedge clk);
    #1;
    check({v.name, " out_valid"}, bus.out_valid, 1'b1);
    check({v.name, " ext_imm"},   bus.ext_imm,   v.imm);
    check({v.name, " carry_out"}, bus.carry_out, v.cout);
    check({v.name, " illegal"},   bus.illegal,   v.ill);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    clr_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] d, e;
    bit         ro_pat[6];
    int         sent, got, cyc;
    vec_t       iv;

    vecs[0]  = '{3'b000, 24'h0004FF, 1'b0, 32'hFF000000, 1'b1, 1'b0, "rot8"};
    vecs[1]  = '{3'b000, 24'h0000AB, 1'b1, 32'h000000AB, 1'b1, 1'b0, "rot0 cin1"};
    vecs[2]  = '{3'b000, 24'h000080, 1'b0, 32'h00000080, 1'b0, 1'b0, "rot0 cin0"};
    vecs[3]  = '{3'b000, 24'h000F01, 1'b1, 32'h00000004, 1'b0, 1'b0, "rot30 wrap"};
    vecs[4]  = '{3'b000, 24'h0001FF, 1'b0, 32'hC000003F, 1'b1, 1'b0, "rot2"};
    vecs[5]  = '{3'b001, 24'h800123, 1'b1, 32'h00000123, 1'b0, 1'b0, "mem up"};
    vecs[6]  = '{3'b001, 24'h000123, 1'b0, 32'hFFFFFEDD, 1'b0, 1'b0, "mem down"};
    vecs[7]  = '{3'b001, 24'h000000, 1'b0, 32'h00000000, 1'b0, 1'b0, "mem -0"};
    vecs[8]  = '{3'b010, 24'hFFFFFE, 1'b0, 32'hFFFFFFF8, 1'b0, 1'b0, "branch neg"};
    vecs[9]  = '{3'b010, 24'h000001, 1'b0, 32'h00000004, 1'b0, 1'b0, "branch pos"};
    vecs[10] = '{3'b011, 24'h800A05, 1'b0, 32'h000000A5, 1'b0, 1'b0, "half up"};
    vecs[11] = '{3'b011, 24'h000A05, 1'b0, 32'hFFFFFF5B, 1'b0, 1'b0, "half down"};
    vecs[12] = '{3'b100, 24'hFFF3C7, 1'b1, 32'h000000C7, 1'b0, 1'b0, "zext8"};
    vecs[13] = '{3'b101, 24'h123456, 1'b1, 32'h00000000, 1'b0, 1'b1, "mode101"};
    vecs[14] = '{3'b110, 24'hFFFFFF, 1'b0, 32'h00000000, 1'b0, 1'b1, "mode110"};
    ro_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    bus.in_valid = 1'b0; bus.imm_src = '0; bus.instr = '0;
    bus.carry_in = 1'b0; bus.out_ready = 1'b0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst out_valid", bus.out_valid, 1'b0);
    check("rst ext_imm",   bus.ext_imm,   32'h0);
    check("rst carry_out", bus.carry_out, 1'b0);
    check("rst illegal",   bus.illegal,   1'b0);
    check("rst err_cnt",   err_cnt,       8'd0);
    check("rst in_ready",  bus.in_ready,  1'b1);

    foreach (vecs[i]) send_one(vecs[i]);
    check("err_cnt after 2 illegal", err_cnt, 8'd2);

    // Stream of 6 with toggling out_ready; occupancy tracked from fires.
    sent = 0; got = 0; cyc = 0; d = '0;
    while (got < 6 && cyc < 100) begin
      @(negedge clk);
      bus.out_ready = ro_pat[cyc % 6];
      bus.in_valid  = (sent < 6);
      bus.imm_src   = IMM_ZEXT8;
      d             = 8'(17 * (sent + 1));
      bus.instr     = {16'h5A5A, d};
      #1;
      check("stream in_ready", bus.in_ready,
            !((sent - got) == 2 && !bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream unexpected output", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("stream data", bus.ext_imm, {24'h0, e});
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(d);
        sent++;
      end
      cyc++;
    end
    check("stream count", got, 6);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1 check("stream no duplicate", bus.out_valid, 1'b0);

    // Saturation: 300 back-to-back illegal requests.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.imm_src   = 3'b111;
      bus.instr     = 24'(i);
      bus.out_ready = 1'b1;
      #1;
      if (i == 10) check("err_cnt mid", err_cnt, 8'd9);
      if (bus.out_valid) begin
        check("sat illegal", bus.illegal, 1'b1);
        check("sat ext_imm", bus.ext_imm, 32'h0);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("err_cnt saturated", err_cnt, 8'd255);
    check("sat drained", bus.out_valid, 1'b0);

    // Clear coinciding with an illegal entering stage 2.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.imm_src  = 3'b111;
    @(negedge clk);
    bus.in_valid = 1'b0;
    clr_err = 1'b1;
    #1 check("clr pre", err_cnt, 8'd255);
    @(negedge clk);
    clr_err = 1'b0;
    #1;
    check("clr wins", err_cnt, 8'd0);
    check("clr out_valid", bus.out_valid, 1'b1);
    check("clr illegal", bus.illegal, 1'b1);
    @(negedge clk);
    #1 check("clr stays", err_cnt, 8'd0);
    iv = '{3'b111, 24'h0, 1'b0, 32'h0, 1'b0, 1'b1, "ill after clr"};
    send_one(iv);
    check("err_cnt after clr+1", err_cnt, 8'd1);

    // Reset mid-stream with both stages full.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.imm_src   = IMM_ZEXT8;
    bus.instr     = 24'h000011;
    @(negedge clk);
    bus.instr     = 24'h000022;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    #1;
    check("mid full out_valid", bus.out_valid, 1'b1);
    check("mid full in_ready", bus.in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst out_valid", bus.out_valid, 1'b0);
    check("mid rst err_cnt", err_cnt, 8'd0);
    check("mid rst in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1 check("post rst out_valid", bus.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
